// File: rtl/vga_timing_pkg.sv
// Shared encodings and standard timing sets for the parameterised VGA controller.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vga_state_e;

  typedef struct packed {
    int unsigned sync;
    int unsigned back;
    int unsigned act;
    int unsigned front;
  } axis_timing_t;

  localparam axis_timing_t H_640X480 = '{sync: 96,  back: 48, act: 640, front: 16};
  localparam axis_timing_t V_640X480 = '{sync: 2,   back: 33, act: 480, front: 10};
  localparam axis_timing_t H_800X600 = '{sync: 128, back: 88, act: 800, front: 40};
  localparam axis_timing_t V_800X600 = '{sync: 4,   back: 23, act: 600, front: 1};

  function automatic int unsigned axis_total(axis_timing_t t);
    return t.sync + t.back + t.act + t.front;
  endfunction

endpackage

// File: rtl/vga_ctrl_param_if.sv
// Pixel-source and display-side signals of the VGA controller.
interface vga_ctrl_param_if #(
  parameter int unsigned DATA_W = 24
);
  logic [DATA_W-1:0]                Data;
  logic                             Data_Req;
  logic [vga_timing_pkg::CNT_W-1:0] H_Addr;
  logic [vga_timing_pkg::CNT_W-1:0] V_Addr;
  logic                             VGA_HS;
  logic                             VGA_VS;
  logic                             VGA_BLK;
  logic [DATA_W-1:0]                VGA_RGB;
  logic                             Frame_Start;

  modport master (
    input  Data,
    output Data_Req, H_Addr, V_Addr, VGA_HS, VGA_VS, VGA_BLK, VGA_RGB, Frame_Start
  );

  modport slave (
    output Data,
    input  Data_Req, H_Addr, V_Addr, VGA_HS, VGA_VS, VGA_BLK, VGA_RGB, Frame_Start
  );
endinterface

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping position counter with sync, active and early-request decode.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned SYNC  = 96,
  parameter int unsigned BACK  = 48,
  parameter int unsigned ACT   = 640,
  parameter int unsigned FRONT = 16,
  parameter int unsigned LEAD  = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             in_sync,
  output logic             in_act,
  output logic             in_req,
  output logic [CNT_W-1:0] req_pos
);

  localparam int unsigned TOTAL   = SYNC + BACK + ACT + FRONT;
  localparam int unsigned ACT_BEG = SYNC + BACK;
  localparam int unsigned REQ_BEG = ACT_BEG - LEAD;

  logic [31:0] cnt_w;

  assign cnt_w   = 32'(cnt);
  assign last    = (cnt_w == TOTAL - 1);
  assign in_sync = (cnt_w < SYNC);
  assign in_act  = (cnt_w >= ACT_BEG) && (cnt_w < ACT_BEG + ACT);
  // Request window is the active window shifted LEAD positions earlier.
  assign in_req  = (cnt_w >= REQ_BEG) && (cnt_w < REQ_BEG + ACT);
  assign req_pos = CNT_W'(cnt_w + LEAD - ACT_BEG);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_ctrl_param.sv
// Parameterised VGA timing controller with lead-time pixel requests.
//   state       | meaning
//   ST_IDLE     | counters held at 0, all outputs at idle level
//   ST_RUN      | frames generated continuously
//   ST_STOPPING | Enable dropped; finish current frame, then idle
module vga_ctrl_param
  import vga_timing_pkg::*;
#(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned H_SYNC   = H_640X480.sync,
  parameter int unsigned H_BACK   = H_640X480.back,
  parameter int unsigned H_ACT    = H_640X480.act,
  parameter int unsigned H_FRONT  = H_640X480.front,
  parameter int unsigned V_SYNC   = V_640X480.sync,
  parameter int unsigned V_BACK   = V_640X480.back,
  parameter int unsigned V_ACT    = V_640X480.act,
  parameter int unsigned V_FRONT  = V_640X480.front,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned REQ_LEAD = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Enable,
  vga_ctrl_param_if.master  bus
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

  if (H_TOTAL > 4096 || V_TOTAL > 4096 || REQ_LEAD < 1 || REQ_LEAD > 4 ||
      REQ_LEAD > H_BACK) begin : g_bad_params
    $fatal(1, "vga_ctrl_param: unsupported timing parameter set");
  end

  vga_state_e       state;
  logic             running;
  logic [CNT_W-1:0] h_cnt, v_cnt, h_pos, v_pos;
  logic             h_last, v_last, h_sync, v_sync, h_act, v_act, h_req, v_req;
  logic             hs_q, vs_q, blk_q, req_q, fs_q;
  logic [CNT_W-1:0] h_addr_q, v_addr_q;
  logic [DATA_W-1:0] rgb_gated;

  assign running = (state != ST_IDLE);

  vga_axis_cnt #(
    .SYNC(H_SYNC), .BACK(H_BACK), .ACT(H_ACT), .FRONT(H_FRONT), .LEAD(REQ_LEAD)
  ) u_h_cnt (
    .Clk(Clk), .Reset_n(Reset_n), .clr(!running), .adv(running),
    .cnt(h_cnt), .last(h_last), .in_sync(h_sync), .in_act(h_act),
    .in_req(h_req), .req_pos(h_pos)
  );

  vga_axis_cnt #(
    .SYNC(V_SYNC), .BACK(V_BACK), .ACT(V_ACT), .FRONT(V_FRONT), .LEAD(0)
  ) u_v_cnt (
    .Clk(Clk), .Reset_n(Reset_n), .clr(!running), .adv(running && h_last),
    .cnt(v_cnt), .last(v_last), .in_sync(v_sync), .in_act(v_act),
    .in_req(v_req), .req_pos(v_pos)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      blk_q    <= 1'b0;
      req_q    <= 1'b0;
      fs_q     <= 1'b0;
      h_addr_q <= '0;
      v_addr_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE:     if (Enable) state <= ST_RUN;
        ST_RUN:      if (!Enable) state <= ST_STOPPING;
        ST_STOPPING: begin
          if (Enable)                   state <= ST_RUN;
          else if (h_last && v_last)    state <= ST_IDLE;
        end
        default:     state <= ST_IDLE;
      endcase

      // Outputs follow the counter decode by one cycle; idle forces them quiet.
      hs_q     <= (running && h_sync) ? HS_POL : ~HS_POL;
      vs_q     <= (running && v_sync) ? VS_POL : ~VS_POL;
      blk_q    <= running && h_act && v_act;
      req_q    <= running && h_req && v_req;
      fs_q     <= running && (h_cnt == '0) && (v_cnt == '0);
      h_addr_q <= (running && h_req && v_req) ? h_pos : '0;
      v_addr_q <= (running && h_req && v_req) ? v_pos : '0;
    end
  end

  assign rgb_gated       = blk_q ? bus.Data : '0;
  assign bus.VGA_RGB     = rgb_gated;
  assign bus.VGA_HS      = hs_q;
  assign bus.VGA_VS      = vs_q;
  assign bus.VGA_BLK     = blk_q;
  assign bus.Data_Req    = req_q;
  assign bus.Frame_Start = fs_q;
  assign bus.H_Addr      = h_addr_q;
  assign bus.V_Addr      = v_addr_q;

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Four controller configurations checked cycle by cycle against a frame-position model.
module tb_vga_ctrl_param;

  localparam int NI = 4;
  localparam int P_HS [NI] = '{96, 96, 4, 4};
  localparam int P_HB [NI] = '{48, 48, 2, 2};
  localparam int P_HA [NI] = '{640, 640, 8, 8};
  localparam int P_HF [NI] = '{16, 16, 2, 2};
  localparam int P_VS [NI] = '{2, 2, 1, 1};
  localparam int P_VB [NI] = '{33, 33, 1, 1};
  localparam int P_VA [NI] = '{480, 480, 4, 4};
  localparam int P_VF [NI] = '{10, 10, 1, 1};
  localparam int P_LD [NI] = '{1, 3, 1, 2};
  localparam bit P_HP [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam bit P_VP [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic Clk = 1'b0;
  logic Reset_n;
  bit   en [NI];
  always #5 Clk = ~Clk;

  logic [23:0] data_drv [NI];
  logic        o_hs [NI], o_vs [NI], o_blk [NI], o_req [NI], o_fs [NI];
  logic [11:0] o_ha [NI], o_va [NI];
  logic [23:0] o_rgb [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_ctrl_param_if #(.DATA_W(24)) vif ();
    vga_ctrl_param #(
      .DATA_W(24),
      .H_SYNC(P_HS[g]), .H_BACK(P_HB[g]), .H_ACT(P_HA[g]), .H_FRONT(P_HF[g]),
      .V_SYNC(P_VS[g]), .V_BACK(P_VB[g]), .V_ACT(P_VA[g]), .V_FRONT(P_VF[g]),
      .HS_POL(P_HP[g]), .VS_POL(P_VP[g]), .REQ_LEAD(P_LD[g])
    ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Enable(en[g]), .bus(vif.master)
    );
    assign vif.Data = data_drv[g];
    assign o_hs[g]  = vif.VGA_HS;
    assign o_vs[g]  = vif.VGA_VS;
    assign o_blk[g] = vif.VGA_BLK;
    assign o_req[g] = vif.Data_Req;
    assign o_fs[g]  = vif.Frame_Start;
    assign o_ha[g]  = vif.H_Addr;
    assign o_va[g]  = vif.V_Addr;
    assign o_rgb[g] = vif.VGA_RGB;
  end

  // Reference model: linear frame position plus a pending-stop flag per controller.
  bit          running [NI];
  bit          stop_pend [NI];
  int          pos [NI];
  logic        x_hs [NI], x_vs [NI], x_blk [NI], x_req [NI], x_fs [NI];
  logic [11:0] x_ha [NI], x_va [NI];
  logic [23:0] x_rgb [NI];
  logic [23:0] hist [NI][5];
  logic [23:0] s0 [NI];
  int          sy [NI];
  int          n_checks = 0;
  int          n_err = 0;

  function automatic logic [23:0] pix(int i, int x, int y);
    return 24'(x + y * sy[i]) + s0[i];
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s inst%0d at %0t: observed %0h expected %0h", tag, inst, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input int i);
    int ht, vt, h, v, hb, vb, hl;
    bit on, vin;
    ht  = P_HS[i] + P_HB[i] + P_HA[i] + P_HF[i];
    vt  = P_VS[i] + P_VB[i] + P_VA[i] + P_VF[i];
    on  = Reset_n && running[i];
    h   = pos[i] % ht;
    v   = pos[i] / ht;
    hb  = P_HS[i] + P_HB[i];
    vb  = P_VS[i] + P_VB[i];
    hl  = h + P_LD[i];
    vin = on && v >= vb && v < vb + P_VA[i];
    x_hs[i]  = (on && h < P_HS[i]) ? P_HP[i] : !P_HP[i];
    x_vs[i]  = (on && v < P_VS[i]) ? P_VP[i] : !P_VP[i];
    x_blk[i] = vin && h >= hb && h < hb + P_HA[i];
    x_req[i] = vin && hl >= hb && hl < hb + P_HA[i];
    x_ha[i]  = x_req[i] ? 12'(hl - hb) : 12'd0;
    x_va[i]  = x_req[i] ? 12'(v - vb) : 12'd0;
    x_fs[i]  = on && pos[i] == 0;
    x_rgb[i] = x_blk[i] ? pix(i, h - hb, v - vb) : 24'd0;
    if (!Reset_n) begin
      running[i] = 1'b0; pos[i] = 0; stop_pend[i] = 1'b0;
    end else if (!running[i]) begin
      if (en[i]) begin running[i] = 1'b1; pos[i] = 0; stop_pend[i] = 1'b0; end
    end else begin
      if (stop_pend[i] && !en[i] && pos[i] == ht * vt - 1) begin
        running[i] = 1'b0; pos[i] = 0;
      end else begin
        pos[i] = (pos[i] + 1) % (ht * vt);
      end
      stop_pend[i] = !en[i];
    end
  endtask

  task automatic step();
    @(posedge Clk);
    for (int i = 0; i < NI; i++) model_edge(i);
    #1;
    // Pixel source: answer each request REQ_LEAD cycles later, garbage otherwise.
    for (int i = 0; i < NI; i++) begin
      for (int k = 4; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0]  = o_req[i] ? pix(i, int'(o_ha[i]), int'(o_va[i])) : 24'($urandom);
      data_drv[i] = hist[i][P_LD[i]];
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("hs", i, 32'(o_hs[i]), 32'(x_hs[i]));
      chk("vs", i, 32'(o_vs[i]), 32'(x_vs[i]));
      chk("blk", i, 32'(o_blk[i]), 32'(x_blk[i]));
      chk("data_req", i, 32'(o_req[i]), 32'(x_req[i]));
      chk("frame_start", i, 32'(o_fs[i]), 32'(x_fs[i]));
      chk("h_addr", i, 32'(o_ha[i]), 32'(x_ha[i]));
      chk("v_addr", i, 32'(o_va[i]), 32'(x_va[i]));
      chk("rgb", i, 32'(o_rgb[i]), 32'(x_rgb[i]));
    end
  endtask

  initial begin
    int n;
    int lat;
    Reset_n = 1'b0;
    en = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < NI; i++) begin
      s0[i] = 24'($urandom);
      sy[i] = int'($urandom_range(1, 4095));
      running[i] = 1'b0; stop_pend[i] = 1'b0; pos[i] = 0;
      data_drv[i] = 24'd0;
      for (int k = 0; k < 5; k++) hist[i][k] = 24'd0;
    end
    repeat (3) step();
    Reset_n = 1'b1;
    repeat (2) step();
    en = '{1'b1, 1'b1, 1'b1, 1'b1};
    repeat (50) step();
    en[2] = 1'b0;
    repeat (150) step();
    en[2] = 1'b1;
    repeat (60) step();
    en[2] = 1'b0;
    repeat (10) step();
    en[2] = 1'b1;
    repeat (200) step();
    en[3] = 1'b0;
    repeat (250) step();
    en[3] = 1'b1;
    repeat (100) step();

    n = 0;
    while (!(running[0] && pos[0] == 36 * 800 + 400) && n < 40000) begin
      step();
      n++;
    end
    chk("reach_mid_line", 0, 32'(n < 40000), 32'd1);
    chk("pre_reset_blk", 0, 32'(o_blk[0]), 32'd1);
    chk("pre_reset_req", 1, 32'(o_req[1]), 32'd1);

    #2 Reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("async_rst_hs", i, 32'(o_hs[i]), 32'(!P_HP[i]));
      chk("async_rst_vs", i, 32'(o_vs[i]), 32'(!P_VP[i]));
      chk("async_rst_blk", i, 32'(o_blk[i]), 32'd0);
      chk("async_rst_req", i, 32'(o_req[i]), 32'd0);
      chk("async_rst_fs", i, 32'(o_fs[i]), 32'd0);
      chk("async_rst_haddr", i, 32'(o_ha[i]), 32'd0);
      chk("async_rst_vaddr", i, 32'(o_va[i]), 32'd0);
      chk("async_rst_rgb", i, 32'(o_rgb[i]), 32'd0);
    end
    repeat (2) step();
    Reset_n = 1'b1;
    lat = 0;
    while (lat < 10) begin
      step();
      lat++;
      if (o_fs[0] === 1'b1) break;
    end
    chk("fs_after_release", 0, 32'(lat), 32'd2);
    repeat (300) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vga_ctrl_param.md
VGA_CTRL_PARAM -- requirements
Module: vga_ctrl_param

Interface
REQ-001 SHALL expose parameter DATA_W, default 24, meaning pixel data width.
REQ-002 SHALL expose parameters H_SYNC, H_BACK, H_ACT, H_FRONT, defaults 96, 48, 640, 16, meaning horizontal segment lengths in Clk cycles.
REQ-003 SHALL expose parameters V_SYNC, V_BACK, V_ACT, V_FRONT, defaults 2, 33, 480, 10, meaning vertical segment lengths in lines.
REQ-004 SHALL expose parameters HS_POL and VS_POL, default 0, meaning asserted sync level (0 = active-low).
REQ-005 SHALL expose parameter REQ_LEAD, default 1, range 1..4, meaning the number of cycles Data_Req leads VGA_BLK.
REQ-006 Clk  input  1  pixel clock; all logic rising-edge.
REQ-007 Reset_n  input  1  reset, asynchronous, active-low.
REQ-008 Enable  input  1  run request; level-sensitive.
REQ-009 Data  input  DATA_W  pixel from source, valid REQ_LEAD cycles after the matching Data_Req cycle.
REQ-010 Data_Req  output  1  pixel request, leads VGA_BLK by REQ_LEAD cycles.
REQ-011 VGA_HS  output  1  horizontal sync.
REQ-012 VGA_VS  output  1  vertical sync.
REQ-013 VGA_BLK  output  1  high during the active pixel window.
REQ-014 VGA_RGB  output  DATA_W  pixel out; Data when VGA_BLK is high, else 0.
REQ-015 H_Addr, V_Addr  output  12 each  coordinates of the pixel being requested; 0 when Data_Req is low.
REQ-016 Frame_Start  output  1  one-cycle pulse at the start of each frame.

Function
REQ-017 SHALL use 12-bit counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), where TOTAL is the sum of the four segments. v_cnt advances when h_cnt wraps; both wrap to 0 together at end of frame.
REQ-018 Sync SHALL be asserted while h_cnt < H_SYNC (HS) and while v_cnt < V_SYNC (VS). Sync is deasserted at the inverse level.
REQ-019 The active window SHALL be h_cnt in [H_SYNC+H_BACK, +H_ACT) and v_cnt in [V_SYNC+V_BACK, +V_ACT).
REQ-020 VGA_HS, VGA_VS, VGA_BLK and Frame_Start SHALL be registered and lag the counter decode by 1 cycle.
REQ-021 Data_Req SHALL be registered and high for exactly H_ACT consecutive cycles per active line. It SHALL rise exactly REQ_LEAD cycles before VGA_BLK rises.
REQ-022 VGA_RGB SHALL be combinational gating: VGA_BLK ? Data : 0.
REQ-023 State machine states are IDLE, RUN and STOPPING:
- IDLE -> RUN when Enable=1; counters start at 0 on the next cycle.
- RUN -> STOPPING when Enable=0.
- STOPPING -> RUN when Enable=1, with no timing disturbance.
- STOPPING -> IDLE after the final cycle of the current frame.
REQ-024 In IDLE, counters SHALL hold 0, sync outputs SHALL be deasserted, and BLK, Data_Req, Frame_Start, addresses and RGB SHALL be 0.
REQ-025 Frame_Start SHALL pulse only in RUN or STOPPING, when h_cnt=0 and v_cnt=0. It coincides with the first VS-asserted cycle.
REQ-026 Parameter sets whose H_TOTAL or V_TOTAL exceeds 4096, or whose REQ_LEAD exceeds H_BACK, SHALL be rejected at elaboration.

Reset
REQ-027 Reset_n low SHALL immediately force state IDLE, counters 0, and all outputs to their IDLE values, including mid-frame.
REQ-028 After Reset_n is released, operation SHALL resume only via the IDLE -> RUN transition.

Structure
REQ-029 Package vga_timing_pkg SHALL hold the state encoding and timing constant sets for 640x480@60 and 800x600@60.
REQ-030 Sub-module vga_axis_cnt (one instance per axis) SHALL implement a wrapping counter with sync/active decode.

Verification
REQ-031 Default parameters, Enable=1, incrementing-counter source on Data_Req:
- HS low for 96 of every 800 cycles.
- BLK high for 640 cycles on each of 480 lines.
- VS low for 1600 cycles per 420000-cycle frame.
REQ-032 Default parameters: Data_Req rises 1 cycle before BLK, and VGA_RGB increments by 1 on every BLK cycle.
REQ-033 REQ_LEAD=3: Data_Req rises 3 cycles before BLK and stays high 640 cycles; H_Addr runs 0..639 and V_Addr matches the line.
REQ-034 Small timings (H 4/2/8/2, V 1/1/4/1) with Enable dropped mid-frame: the frame completes, then IDLE outputs hold. Re-asserting Enable during STOPPING gives a gap-free next Frame_Start.
REQ-035 Reset_n pulsed low mid active line: all outputs go to IDLE values asynchronously. With Enable=1, the first Frame_Start occurs 2 cycles after release.
REQ-036 HS_POL=1, VS_POL=1: sync pulses are high-active, and the idle sync level is low.
